// File: rtl/mem_request_unit_if.sv
// rtl/mem_request_unit_if.sv - core command/response and RAM request/acknowledge interfaces
// Master drives the request side, slave answers it.
interface mem_cmd_if;
  logic        cmdValid;
  logic        cmdWrite;
  logic [31:0] cmdAddress;
  logic [31:0] cmdData;
  logic        cmdReady;
  logic        rspValid;
  logic [31:0] rspData;
  logic        rspError;

  modport master (
    output cmdValid, cmdWrite, cmdAddress, cmdData,
    input  cmdReady, rspValid, rspData, rspError
  );
  modport slave (
    input  cmdValid, cmdWrite, cmdAddress, cmdData,
    output cmdReady, rspValid, rspData, rspError
  );
endinterface

interface mem_ram_if;
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;

  modport master (
    output ramAddress, ramOut, readReq, writeReq,
    input  ramValue, readAck, writeAck
  );
  modport slave (
    input  ramAddress, ramOut, readReq, writeReq,
    output ramValue, readAck, writeAck
  );
endinterface

// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - single-command RAM initiator with ack timeout
// IDLE accepts, ISSUE emits a one-cycle request, WAIT collects the matching ack.
module mem_request_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNTW    = 8
) (
  input  logic       clk,
  input  logic       reset,
  mem_cmd_if.slave   core,
  mem_ram_if.master  ram
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic              is_write_q, is_write_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic              ack;

  // Only the ack matching the outstanding command type counts.
  assign ack = is_write_q ? ram.writeAck : ram.readAck;

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (core.cmdValid && ready_q) begin
          addr_d     = core.cmdAddress;
          is_write_d = core.cmdWrite;
          if (core.cmdWrite) begin
            wdata_d  = core.cmdData;
            wr_req_d = 1'b1;
          end else begin
            rd_req_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ack) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = is_write_q ? 32'h0 : ram.ramValue;
          state_d     = IDLE;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'h0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 32'h0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
    end
  end

  assign core.cmdReady = ready_q;
  assign core.rspValid = rsp_valid_q;
  assign core.rspError = rsp_err_q;
  assign core.rspData  = rsp_data_q;
  assign ram.ramAddress = addr_q;
  assign ram.ramOut     = wdata_q;
  assign ram.readReq    = rd_req_q;
  assign ram.writeReq   = wr_req_q;

endmodule
